// File: rtl/dft_pkg.sv
// dft_pkg: widths shared across the DFT chain, peak-search FSM states and the
// accumulator-to-magnitude truncation shift.
package dft_pkg;
  localparam int DFT_ACCUM_WIDTH = 48;
  localparam int DFT_MAG_WIDTH = 24;
  localparam int DFT_POWER_WIDTH = 2 * DFT_MAG_WIDTH;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} peak_state_e;
  function automatic int trunc_shift(int accum_width, int mag_width);
    return accum_width - mag_width;
  endfunction
endpackage

// File: rtl/dft_peak_search_if.sv
// dft_peak_search_if: accumulator snapshot inputs and per-bin/peak results of dft_peak_search.
interface dft_peak_search_if
  import dft_pkg::*;
#(
  parameter int ACCUM_WIDTH = DFT_ACCUM_WIDTH,
  parameter int NUM_BINS = 16,
  parameter int MAG_WIDTH = DFT_MAG_WIDTH,
  parameter int POWER_WIDTH = 2 * MAG_WIDTH,
  parameter int IDX_WIDTH = $clog2(NUM_BINS)
);
  logic valid_i;
  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0] A_real_i;
  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0] A_imag_i;
  logic [POWER_WIDTH-1:0] threshold_i;
  logic power_valid_o;
  logic [IDX_WIDTH-1:0] power_idx_o;
  logic [POWER_WIDTH-1:0] power_o;
  logic [IDX_WIDTH-1:0] peak_idx_o;
  logic [POWER_WIDTH-1:0] peak_power_o;
  logic peak_found_o;
  logic done_o;
  logic busy_o;
  logic overrun_o;
  modport master (
    output valid_i, A_real_i, A_imag_i, threshold_i,
    input power_valid_o, power_idx_o, power_o, peak_idx_o, peak_power_o,
    input peak_found_o, done_o, busy_o, overrun_o
  );
  modport slave (
    input valid_i, A_real_i, A_imag_i, threshold_i,
    output power_valid_o, power_idx_o, power_o, peak_idx_o, peak_power_o,
    output peak_found_o, done_o, busy_o, overrun_o
  );
endinterface

// File: rtl/dft_power_calc.sv
// dft_power_calc: truncate -> square -> sum pipeline producing |A|^2 per bin,
// with the bin index carried alongside.
module dft_power_calc
  import dft_pkg::*;
#(
  parameter int ACCUM_WIDTH = DFT_ACCUM_WIDTH,
  parameter int MAG_WIDTH = DFT_MAG_WIDTH,
  parameter int POWER_WIDTH = 2 * MAG_WIDTH,
  parameter int IDX_WIDTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic [IDX_WIDTH-1:0] idx_i,
  input  logic [ACCUM_WIDTH-1:0] re_i,
  input  logic [ACCUM_WIDTH-1:0] im_i,
  output logic valid_o,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic [POWER_WIDTH-1:0] power_o
);
  localparam int SHIFT = trunc_shift(ACCUM_WIDTH, MAG_WIDTH);
  logic [MAG_WIDTH-1:0] re_t_q, im_t_q;
  logic signed [2*MAG_WIDTH-2:0] re_x, im_x;
  logic [2*MAG_WIDTH-2:0] re_sq_q, im_sq_q;
  logic v1_q, v2_q;
  logic [IDX_WIDTH-1:0] idx1_q, idx2_q;
  // Slicing above SHIFT is the arithmetic shift with only the low MAG_WIDTH bits kept.
  assign re_x = {{(MAG_WIDTH-1){re_t_q[MAG_WIDTH-1]}}, re_t_q};
  assign im_x = {{(MAG_WIDTH-1){im_t_q[MAG_WIDTH-1]}}, im_t_q};
  assign valid_o = v2_q;
  assign idx_o = idx2_q;
  assign power_o = POWER_WIDTH'(re_sq_q) + POWER_WIDTH'(im_sq_q);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      re_t_q <= '0;
      im_t_q <= '0;
      re_sq_q <= '0;
      im_sq_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      idx1_q <= '0;
      idx2_q <= '0;
    end else begin
      re_t_q <= re_i[SHIFT +: MAG_WIDTH];
      im_t_q <= im_i[SHIFT +: MAG_WIDTH];
      v1_q <= valid_i;
      idx1_q <= idx_i;
      re_sq_q <= re_x * re_x;
      im_sq_q <= im_x * im_x;
      v2_q <= v1_q;
      idx2_q <= idx1_q;
    end
  end
endmodule

// File: rtl/dft_peak_search.sv
// dft_peak_search: snapshots NUM_BINS DFT accumulators, streams per-bin power and
// reports the strongest bin; DFT_PEAK_THRESHOLD_EN adds a minimum-power qualifier.
module dft_peak_search
  import dft_pkg::*;
#(
  parameter int ACCUM_WIDTH = DFT_ACCUM_WIDTH,
  parameter int NUM_BINS = 16,
  parameter int MAG_WIDTH = DFT_MAG_WIDTH,
  parameter int POWER_WIDTH = 2 * MAG_WIDTH,
  parameter int IDX_WIDTH = $clog2(NUM_BINS)
) (
  input logic clk_i,
  input logic rst_i,
  dft_peak_search_if.slave bus
);
  peak_state_e state_q, state_d;
  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0] snap_re_q, snap_im_q;
  logic [IDX_WIDTH-1:0] cnt_q, max_idx_q, peak_idx_q, pw_idx, new_idx;
  logic [POWER_WIDTH-1:0] max_pow_q, peak_pow_q, pw_pow, new_pow;
  logic pw_valid, overrun_q, accept, last_issue, last_power, take;
  assign accept = state_q == IDLE && bus.valid_i;
  assign last_issue = cnt_q == IDX_WIDTH'(NUM_BINS - 1);
  assign last_power = pw_valid && pw_idx == IDX_WIDTH'(NUM_BINS - 1);
  // Bin 0 seeds the max; strict compare keeps the lowest index on ties.
  assign take = pw_idx == '0 || pw_pow > max_pow_q;
  assign new_idx = take ? pw_idx : max_idx_q;
  assign new_pow = take ? pw_pow : max_pow_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = bus.valid_i ? SCAN : IDLE;
      SCAN: state_d = last_issue ? DRAIN : SCAN;
      DRAIN: state_d = last_power ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  dft_power_calc #(
    .ACCUM_WIDTH(ACCUM_WIDTH),
    .MAG_WIDTH(MAG_WIDTH),
    .POWER_WIDTH(POWER_WIDTH),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_power (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .valid_i(state_q == SCAN),
    .idx_i(cnt_q),
    .re_i(snap_re_q[cnt_q]),
    .im_i(snap_im_q[cnt_q]),
    .valid_o(pw_valid),
    .idx_o(pw_idx),
    .power_o(pw_pow)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      snap_re_q <= '0;
      snap_im_q <= '0;
      cnt_q <= '0;
      max_idx_q <= '0;
      max_pow_q <= '0;
      peak_idx_q <= '0;
      peak_pow_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      overrun_q <= bus.valid_i && state_q != IDLE;
      if (accept) begin
        snap_re_q <= bus.A_real_i;
        snap_im_q <= bus.A_imag_i;
        cnt_q <= '0;
        max_idx_q <= '0;
        max_pow_q <= '0;
      end
      if (state_q == SCAN) cnt_q <= cnt_q + 1'b1;
      if (pw_valid) begin
        max_idx_q <= new_idx;
        max_pow_q <= new_pow;
      end
      // Publish on the last bin so the result is visible in the done cycle and held after.
      if (last_power) begin
        peak_idx_q <= new_idx;
        peak_pow_q <= new_pow;
      end
    end
  end
  assign bus.power_valid_o = pw_valid;
  assign bus.power_idx_o = pw_idx;
  assign bus.power_o = pw_pow;
  assign bus.peak_idx_o = peak_idx_q;
  assign bus.peak_power_o = peak_pow_q;
  assign bus.done_o = state_q == DONE;
  assign bus.busy_o = state_q != IDLE;
  assign bus.overrun_o = overrun_q;
`ifdef DFT_PEAK_THRESHOLD_EN
  assign bus.peak_found_o = state_q == DONE && peak_pow_q >= bus.threshold_i;
`else
  assign bus.peak_found_o = state_q == DONE;
`endif
endmodule

// File: tb/tb_dft_peak_search.sv
// tb_dft_peak_search: directed and randomized scans of dft_peak_search checked
// against a per-bin power / peak model.
`timescale 1ns/1ps
module tb_dft_peak_search;
  localparam int AW = 48, NB = 16, MW = 24, PW = 48, IW = 4, SH = AW - MW;
  typedef longint arr_t [NB];
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;
  dft_peak_search_if #(.ACCUM_WIDTH(AW), .NUM_BINS(NB), .MAG_WIDTH(MW), .POWER_WIDTH(PW), .IDX_WIDTH(IW)) bus ();
  dft_peak_search #(.ACCUM_WIDTH(AW), .NUM_BINS(NB), .MAG_WIDTH(MW), .POWER_WIDTH(PW), .IDX_WIDTH(IW)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );
  int n_cmp = 0;
  int n_fail = 0;
  arr_t m_re, m_im, g_re, g_im;
  longint thr;
  logic [63:0] pv_mask, done_mask, busy_mask, ovr_mask, zero_mask, found_mask;
  longint pow_at [64];
  int idx_at [64];
  int pk_idx_at [64];
  longint pk_pow_at [64];
  function automatic longint rnd48();
    longint x;
    x = longint'({$urandom(), $urandom()});
    return (x <<< 16) >>> 16;
  endfunction
  function automatic longint rnd_bin();
    if ($urandom_range(0, 3) == 0) return rnd48();
    return ((longint'($urandom_range(0, 8)) - 4) <<< SH) + longint'($urandom_range(0, (1 << SH) - 1));
  endfunction
  function automatic longint bin_pow(longint re, longint im);
    longint rt, it;
    rt = re >>> SH;
    it = im >>> SH;
    return rt * rt + it * it;
  endfunction
  function automatic int peak_of(arr_t re, arr_t im);
    int best = 0;
    for (int i = 1; i < NB; i++)
      if (bin_pow(re[i], im[i]) > bin_pow(re[best], im[best])) best = i;
    return best;
  endfunction
  function automatic logic exp_found(longint pp, longint t);
`ifdef DFT_PEAK_THRESHOLD_EN
    return pp >= t;
`else
    return (pp >= 0) || (t >= 0) || 1'b1;
`endif
  endfunction
  function automatic logic all_zero();
    return !(bus.power_valid_o || bus.done_o || bus.busy_o || bus.overrun_o || bus.peak_found_o) &&
           bus.power_o == '0 && bus.power_idx_o == '0 && bus.peak_idx_o == '0 && bus.peak_power_o == '0;
  endfunction
  task automatic clear_pattern();
    for (int i = 0; i < NB; i++) begin
      m_re[i] = 0;
      m_im[i] = 0;
    end
  endtask
  // Valid at cycle T (c=0); vmask/rmask drive valid_i/rst_i in cycle T+c; garbage inputs from T+1.
  task automatic run_scan(input int n, input logic [63:0] vmask, input logic [63:0] rmask);
    pv_mask = '0; done_mask = '0; busy_mask = '0; ovr_mask = '0; zero_mask = '0; found_mask = '0;
    for (int i = 0; i < NB; i++) begin
      bus.A_real_i[i] = m_re[i][AW-1:0];
      bus.A_imag_i[i] = m_im[i][AW-1:0];
    end
    bus.threshold_i = thr[PW-1:0];
    bus.valid_i = 1'b1;
    for (int c = 1; c < n; c++) begin
      @(posedge clk_i);
      #1;
      pv_mask[c] = bus.power_valid_o;
      pow_at[c] = longint'(bus.power_o);
      idx_at[c] = int'(bus.power_idx_o);
      done_mask[c] = bus.done_o;
      busy_mask[c] = bus.busy_o;
      ovr_mask[c] = bus.overrun_o;
      found_mask[c] = bus.peak_found_o;
      pk_idx_at[c] = int'(bus.peak_idx_o);
      pk_pow_at[c] = longint'(bus.peak_power_o);
      zero_mask[c] = all_zero();
      if (c == 1)
        for (int i = 0; i < NB; i++) begin
          g_re[i] = rnd48();
          g_im[i] = rnd48();
          bus.A_real_i[i] = g_re[i][AW-1:0];
          bus.A_imag_i[i] = g_im[i][AW-1:0];
        end
      bus.valid_i = vmask[c];
      rst_i = rmask[c];
    end
    bus.valid_i = 1'b0;
    rst_i = 1'b0;
  endtask
  task automatic test_reset();
    rst_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.threshold_i = '0;
    bus.A_real_i = '1;
    bus.A_imag_i = '1;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if (bus.power_valid_o !== 1'b0 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got pv=%b done=%b busy=%b ovr=%b exp all 0", bus.power_valid_o, bus.done_o, bus.busy_o, bus.overrun_o);
    end
    n_cmp++;
    if (bus.peak_idx_o !== '0 || bus.peak_power_o !== '0 || bus.peak_found_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_peak got idx=%0d pow=%0d found=%b exp 0", bus.peak_idx_o, bus.peak_power_o, bus.peak_found_o);
    end
    n_cmp++;
    if (bus.power_o !== '0 || bus.power_idx_o !== '0) begin
      n_fail++;
      $display("FAIL reset_power got pow=%0d idx=%0d exp 0", bus.power_o, bus.power_idx_o);
    end
    bus.valid_i = 1'b0;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy got %b exp 0", bus.busy_o);
    end
  endtask
  task automatic test_single_tone();
    clear_pattern();
    m_re[5] = 3 <<< SH;
    m_im[5] = 4 <<< SH;
    thr = 25;
    run_scan(22, '0, '0);
    n_cmp++;
    if (pv_mask !== 64'h7FFF8) begin
      n_fail++;
      $display("FAIL tone_pv_window got %h exp %h", pv_mask, 64'h7FFF8);
    end
    for (int k = 0; k < NB; k++) begin
      n_cmp++;
      if (idx_at[3+k] !== k || pow_at[3+k] !== bin_pow(m_re[k], m_im[k])) begin
        n_fail++;
        $display("FAIL tone_bin%0d got idx=%0d pow=%0d exp idx=%0d pow=%0d", k, idx_at[3+k], pow_at[3+k], k, bin_pow(m_re[k], m_im[k]));
      end
    end
    n_cmp++;
    if (pow_at[8] !== 25) begin
      n_fail++;
      $display("FAIL tone_power_t8 got %0d exp 25", pow_at[8]);
    end
    n_cmp++;
    if (done_mask !== (64'd1 << 19) || busy_mask !== 64'hFFFFE || ovr_mask !== '0) begin
      n_fail++;
      $display("FAIL tone_ctrl got done=%h busy=%h ovr=%h exp done=%h busy=%h ovr=0", done_mask, busy_mask, ovr_mask, 64'd1 << 19, 64'hFFFFE);
    end
    n_cmp++;
    if (pk_idx_at[19] !== 5 || pk_pow_at[19] !== 25 || pk_idx_at[20] !== 5 || pk_pow_at[20] !== 25) begin
      n_fail++;
      $display("FAIL tone_peak got idx=%0d/%0d pow=%0d/%0d exp 5 and 25 held", pk_idx_at[19], pk_idx_at[20], pk_pow_at[19], pk_pow_at[20]);
    end
    n_cmp++;
    if (found_mask !== (64'(exp_found(25, thr)) << 19)) begin
      n_fail++;
      $display("FAIL tone_found got %h exp %h", found_mask, 64'(exp_found(25, thr)) << 19);
    end
  endtask
  task automatic test_tie_negative();
    clear_pattern();
    m_re[2] = -(2 <<< SH);
    m_re[9] = -(2 <<< SH);
    thr = 0;
    run_scan(22, '0, '0);
    for (int k = 0; k < NB; k++) begin
      n_cmp++;
      if (pv_mask[3+k] !== 1'b1 || idx_at[3+k] !== k || pow_at[3+k] !== bin_pow(m_re[k], m_im[k])) begin
        n_fail++;
        $display("FAIL tie_bin%0d got v=%b idx=%0d pow=%0d exp pow=%0d", k, pv_mask[3+k], idx_at[3+k], pow_at[3+k], bin_pow(m_re[k], m_im[k]));
      end
    end
    n_cmp++;
    if (done_mask[19] !== 1'b1 || pk_idx_at[19] !== 2 || pk_pow_at[19] !== 4) begin
      n_fail++;
      $display("FAIL tie_peak got done=%b idx=%0d pow=%0d exp 1 2 4", done_mask[19], pk_idx_at[19], pk_pow_at[19]);
    end
  endtask
  task automatic test_full_scale();
    clear_pattern();
    m_re[15] = -(longint'(1) <<< 47);
    m_im[15] = -(longint'(1) <<< 47);
    thr = longint'(1) <<< 47;
    run_scan(22, '0, '0);
    n_cmp++;
    if (pv_mask[18] !== 1'b1 || idx_at[18] !== 15 || pow_at[18] !== (longint'(1) <<< 47)) begin
      n_fail++;
      $display("FAIL full_scale_power got v=%b idx=%0d pow=%0d exp 1 15 %0d", pv_mask[18], idx_at[18], pow_at[18], longint'(1) <<< 47);
    end
    n_cmp++;
    if (pk_idx_at[19] !== 15 || pk_pow_at[19] !== (longint'(1) <<< 47) || found_mask[19] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_scale_peak got idx=%0d pow=%0d found=%b exp 15 %0d 1", pk_idx_at[19], pk_pow_at[19], found_mask[19], longint'(1) <<< 47);
    end
  endtask
  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int p;
      longint pp;
      for (int i = 0; i < NB; i++) begin
        m_re[i] = rnd_bin();
        m_im[i] = rnd_bin();
      end
      p = peak_of(m_re, m_im);
      pp = bin_pow(m_re[p], m_im[p]);
      thr = pp + longint'($urandom_range(0, 2)) - 1;
      run_scan(22, '0, '0);
      for (int k = 0; k < NB; k++) begin
        n_cmp++;
        if (pv_mask[3+k] !== 1'b1 || idx_at[3+k] !== k || pow_at[3+k] !== bin_pow(m_re[k], m_im[k])) begin
          n_fail++;
          $display("FAIL rand%0d_bin%0d got v=%b idx=%0d pow=%0d exp pow=%0d", it, k, pv_mask[3+k], idx_at[3+k], pow_at[3+k], bin_pow(m_re[k], m_im[k]));
        end
      end
      n_cmp++;
      if (done_mask !== (64'd1 << 19) || pk_idx_at[19] !== p || pk_pow_at[19] !== pp || found_mask[19] !== exp_found(pp, thr)) begin
        n_fail++;
        $display("FAIL rand%0d_peak got done=%h idx=%0d pow=%0d found=%b exp idx=%0d pow=%0d found=%b",
                 it, done_mask, pk_idx_at[19], pk_pow_at[19], found_mask[19], p, pp, exp_found(pp, thr));
      end
    end
  endtask
  task automatic test_threshold();
    for (int t = 26; t >= 25; t--) begin
      clear_pattern();
      m_re[5] = 3 <<< SH;
      m_im[5] = 4 <<< SH;
      thr = t;
      run_scan(22, '0, '0);
      n_cmp++;
      if (found_mask[19] !== exp_found(25, thr) || pk_idx_at[19] !== 5 || pk_pow_at[19] !== 25) begin
        n_fail++;
        $display("FAIL threshold_%0d got found=%b idx=%0d pow=%0d exp found=%b idx=5 pow=25", t, found_mask[19], pk_idx_at[19], pk_pow_at[19], exp_found(25, thr));
      end
    end
  endtask
  task automatic test_overrun();
    int p, q;
    for (int i = 0; i < NB; i++) begin
      m_re[i] = rnd_bin();
      m_im[i] = rnd_bin();
    end
    p = peak_of(m_re, m_im);
    thr = 0;
    run_scan(42, (64'd1 << 10) | (64'd1 << 19) | (64'd1 << 20), '0);
    q = peak_of(g_re, g_im);
    n_cmp++;
    if (ovr_mask !== ((64'd1 << 11) | (64'd1 << 20))) begin
      n_fail++;
      $display("FAIL overrun_pulses got %h exp %h", ovr_mask, (64'd1 << 11) | (64'd1 << 20));
    end
    for (int k = 0; k < NB; k++) begin
      n_cmp++;
      if (idx_at[3+k] !== k || pow_at[3+k] !== bin_pow(m_re[k], m_im[k])) begin
        n_fail++;
        $display("FAIL overrun_bin%0d got idx=%0d pow=%0d exp pow=%0d", k, idx_at[3+k], pow_at[3+k], bin_pow(m_re[k], m_im[k]));
      end
    end
    n_cmp++;
    if (pk_idx_at[19] !== p || pk_pow_at[19] !== bin_pow(m_re[p], m_im[p])) begin
      n_fail++;
      $display("FAIL overrun_first_peak got idx=%0d pow=%0d exp idx=%0d pow=%0d", pk_idx_at[19], pk_pow_at[19], p, bin_pow(m_re[p], m_im[p]));
    end
    n_cmp++;
    if (done_mask !== ((64'd1 << 19) | (64'd1 << 39)) || busy_mask[21] !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_reaccept got done=%h busy21=%b exp done=%h busy21=1", done_mask, busy_mask[21], (64'd1 << 19) | (64'd1 << 39));
    end
    n_cmp++;
    if (pk_idx_at[39] !== q || pk_pow_at[39] !== bin_pow(g_re[q], g_im[q])) begin
      n_fail++;
      $display("FAIL overrun_second_peak got idx=%0d pow=%0d exp idx=%0d pow=%0d", pk_idx_at[39], pk_pow_at[39], q, bin_pow(g_re[q], g_im[q]));
    end
  endtask
  task automatic test_reset_mid_scan();
    int q;
    for (int i = 0; i < NB; i++) begin
      m_re[i] = rnd_bin();
      m_im[i] = rnd_bin();
    end
    thr = 0;
    run_scan(30, 64'd1 << 8, 64'd1 << 6);
    q = peak_of(g_re, g_im);
    n_cmp++;
    if (zero_mask[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_zero got zero=%b exp 1", zero_mask[7]);
    end
    n_cmp++;
    if (done_mask !== (64'd1 << 27) || ovr_mask !== '0) begin
      n_fail++;
      $display("FAIL midreset_done got done=%h ovr=%h exp done=%h ovr=0", done_mask, ovr_mask, 64'd1 << 27);
    end
    n_cmp++;
    if (pk_idx_at[27] !== q || pk_pow_at[27] !== bin_pow(g_re[q], g_im[q])) begin
      n_fail++;
      $display("FAIL midreset_peak got idx=%0d pow=%0d exp idx=%0d pow=%0d", pk_idx_at[27], pk_pow_at[27], q, bin_pow(g_re[q], g_im[q]));
    end
  endtask
  initial begin
    bus.valid_i = 1'b0;
    bus.A_real_i = '0;
    bus.A_imag_i = '0;
    bus.threshold_i = '0;
    test_reset();
    test_single_tone();
    test_tie_negative();
    test_full_scale();
    test_random();
    test_threshold();
    test_overrun();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
